// File: rtl/cnt_job_dispatcher.sv
// Count-job dispatcher: queues jobs from an upstream port, issues them one at a time
// to a counter engine, and posts a one-cycle completion record (done or watchdog timeout).
//
// state   | meaning
// S_IDLE  | waiting for a queued job and an idle engine
// S_ISSUE | o_run pulse; head job popped, watchdog cleared
// S_WAIT  | waiting for engine done; watchdog counting
// S_CPL   | completion record posted
module cnt_job_dispatcher #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 300,
    parameter int DONE_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    input  logic [7:0]        i_req_num,
    output logic              o_req_ready,
    output logic              o_run,
    output logic [7:0]        o_num_cnt,
    input  logic              i_idle,
    input  logic              i_running,
    input  logic              i_done,
    output logic              o_cpl_valid,
    output logic [7:0]        o_cpl_num,
    output logic              o_cpl_err,
    output logic              o_busy,
    output logic [DONE_W-1:0] o_jobs_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CPL} state_t;

    state_t state, state_nxt;
    logic   err_nxt;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             push, pop;
    logic [TMR_W-1:0] timer;

    // Engine running status is informational only.
    logic unused_running;
    assign unused_running = i_running;

    assign o_req_ready = (count != DEPTH_C);
    assign push        = i_req_valid && o_req_ready;
    assign pop         = (state == S_ISSUE);

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_req_num;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE:  if (count != '0 && i_idle) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                // done takes priority over a simultaneous watchdog expiry
                if (i_done) begin
                    state_nxt = S_CPL;
                end else if (timer == TMR_LAST) begin
                    state_nxt = S_CPL;
                    err_nxt   = 1'b1;
                end
            end
            S_CPL:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_run       <= 1'b0;
            o_num_cnt   <= '0;
            o_cpl_valid <= 1'b0;
            o_cpl_num   <= '0;
            o_cpl_err   <= 1'b0;
            o_busy      <= 1'b0;
            o_jobs_done <= '0;
            timer       <= '0;
        end else begin
            o_run       <= (state_nxt == S_ISSUE);
            o_cpl_valid <= (state_nxt == S_CPL);
            o_busy      <= (state_nxt != S_IDLE) || (count_nxt != '0);
            if (state == S_IDLE && state_nxt == S_ISSUE) begin
                o_num_cnt <= mem[rd_ptr];
            end
            if (state_nxt == S_CPL) begin
                o_cpl_num <= o_num_cnt;
                o_cpl_err <= err_nxt;
                if (!err_nxt && o_jobs_done != '1) begin
                    o_jobs_done <= o_jobs_done + DONE_W'(1);
                end
            end
            if (state == S_ISSUE) begin
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

endmodule
